booth_divider: RTL and testbench

Sequential signed integer divider. It is the inverse operation of the team's combinational Booth multiplier and uses the same two's-complement operand width and conventions. Each operation takes a start pulse and produces one quotient bit per clock using restoring division on operand magnitudes, then applies a sign fix-up. Multiplier output can be fed back through this block to check results (out = in1*in2 implies out/in1 = in2).

---
 rtl/booth_divider.sv | 133 +++++++++++++
 tb/tb_booth_divider.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// Sequential signed divider: one restoring-division quotient bit per clock
// on operand magnitudes, followed by a sign fix-up cycle.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   start             begin operation (accepted only while busy==0)
//   dividend, divisor signed operands, sampled on the accept edge
//   busy              high in CALC and FIX
//   done              one-cycle pulse in FIN; results valid from then on
//   quotient          signed quotient, truncated toward zero
//   remainder         signed remainder, sign follows the dividend
//   div_by_zero       set with done for a zero divisor, held until next accept
module booth_divider #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        FIN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               sdd;
    logic               sdv;
    logic [WIDTH-1:0]   dvm;
    logic [WIDTH-1:0]   qr;
    logic [WIDTH:0]     rr;

    logic [WIDTH-1:0]   dd_mag;
    logic [WIDTH-1:0]   dv_mag;
    logic [WIDTH:0]     rsh;
    logic [WIDTH+1:0]   diff;
    logic               accept;

    // Magnitude of the most negative value wraps to 2**(WIDTH-1),
    // which is correct when read as unsigned.
    always_comb begin
        dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
        dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
    end

    // Partial remainder shifted left with the next dividend bit from Q.
    // The extra top bit of diff is the borrow of the trial subtraction.
    always_comb begin
        rsh  = {rr[WIDTH-1:0], qr[WIDTH-1]};
        diff = {1'b0, rsh} - {2'b00, dvm};
    end

    assign accept = start && (state == IDLE || state == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sdd         <= 1'b0;
            sdv         <= 1'b0;
            dvm         <= '0;
            qr          <= '0;
            rr          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, FIN: begin
                    if (accept) begin
                        sdd         <= dividend[WIDTH-1];
                        sdv         <= divisor[WIDTH-1];
                        dvm         <= dv_mag;
                        qr          <= dd_mag;
                        rr          <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor skips the datapath entirely.
                            state       <= FIN;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (diff[WIDTH+1]) begin
                        rr <= rsh;
                    end else begin
                        rr <= diff[WIDTH:0];
                    end
                    qr  <= {qr[WIDTH-2:0], ~diff[WIDTH+1]};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= (sdd ^ sdv) ? -qr : qr;
                    remainder <= sdd ? -rr[WIDTH-1:0] : rr[WIDTH-1:0];
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= FIN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Directed and exhaustive checks for booth_divider at WIDTH=6:
// latency, busy window, signs, overflow, zero divisor, restart and reset.
module tb_booth_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] dividend;
    logic [5:0] divisor;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       div_by_zero;

    int n_chk;
    int n_fail;

    booth_divider #(
        .WIDTH(6),
        .CNT_W(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        bit z;
        int lat;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; the following posedge is the accept edge.
    task automatic launch(input int a, input int b);
        dividend = 6'(a);
        divisor  = 6'(b);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the accept edge until done; -1 on timeout.
    task automatic wait_done(output int lat, output bit bok);
        lat = -1;
        bok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) bok = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        bit bok;
        @(negedge clk);
        launch(v.a, v.b);
        wait_done(lat, bok);
        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_busy"}, {31'd0, bok}, 32'd1);
        chk({nm, "_finbusy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_q"}, {26'd0, quotient}, {26'd0, 6'(v.q)});
        chk({nm, "_r"}, {26'd0, remainder}, {26'd0, 6'(v.r)});
        chk({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, v.z});
    endtask

    initial begin
        int lat;
        bit bok;
        bit seen;
        n_chk  = 0;
        n_fail = 0;

        tv[0]  = '{13, 4, 3, 1, 1'b0, 8};
        tv[1]  = '{-13, 4, -3, -1, 1'b0, 8};
        tv[2]  = '{13, -4, -3, 1, 1'b0, 8};
        tv[3]  = '{-13, -4, 3, -1, 1'b0, 8};
        tv[4]  = '{-32, -1, -32, 0, 1'b0, 8};
        tv[5]  = '{-32, 1, -32, 0, 1'b0, 8};
        tv[6]  = '{31, 31, 1, 0, 1'b0, 8};
        tv[7]  = '{0, -5, 0, 0, 1'b0, 8};
        tv[8]  = '{20, 3, 6, 2, 1'b0, 8};
        tv[9]  = '{-7, 0, -1, -7, 1'b1, 1};
        tv[10] = '{5, 7, 0, 5, 1'b0, 8};
        tv[11] = '{-31, 2, -15, -1, 1'b0, 8};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {26'd0, quotient}, 32'd0);
        chk("rst_r", {26'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(tv[i], $sformatf("vec%0d", i));
        end

        // 7/0 then 9/2 started in the FIN cycle clears the flag.
        @(negedge clk);
        launch(7, 0);
        wait_done(lat, bok);
        chk("dz_lat", lat, 1);
        chk("dz_q", {26'd0, quotient}, 32'h3f);
        chk("dz_r", {26'd0, remainder}, 32'd7);
        chk("dz_flag", {31'd0, div_by_zero}, 32'd1);
        launch(9, 2);
        @(negedge clk);
        chk("dz_clear", {31'd0, div_by_zero}, 32'd0);
        chk("dz_donefall", {31'd0, done}, 32'd0);
        chk("dz_qhold", {26'd0, quotient}, 32'h3f);
        wait_done(lat, bok);
        chk("dz_next_lat", lat, 7);
        chk("dz_next_q", {26'd0, quotient}, 32'd4);
        chk("dz_next_r", {26'd0, remainder}, 32'd1);

        // Start pulse while busy is ignored; FIN restart is accepted.
        @(negedge clk);
        launch(20, 3);
        repeat (3) @(negedge clk);
        launch(1, 1);
        wait_done(lat, bok);
        chk("ign_lat", lat, 5);
        chk("ign_q", {26'd0, quotient}, 32'd6);
        chk("ign_r", {26'd0, remainder}, 32'd2);
        launch(13, 4);
        @(negedge clk);
        chk("b2b_done", {31'd0, done}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bok);
        chk("b2b_lat", lat, 7);
        chk("b2b_q", {26'd0, quotient}, 32'd3);
        chk("b2b_r", {26'd0, remainder}, 32'd1);

        // Reset in the middle of 25/5 aborts it.
        @(negedge clk);
        launch(25, 5);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q", {26'd0, quotient}, 32'd0);
        chk("abort_r", {26'd0, remainder}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (done) seen = 1'b1;
        end
        chk("abort_nodone", {31'd0, seen}, 32'd0);
        run_vec('{25, 5, 5, 0, 1'b0, 8}, "after_rst");

        // Every non-zero-divisor pair against truncating / and %.
        for (int a = -32; a < 32; a++) begin
            for (int b = -32; b < 32; b++) begin
                int qe;
                int re;
                int qa;
                int ra;
                if (b == 0) continue;
                qe = a / b;
                re = a % b;
                @(negedge clk);
                launch(a, b);
                wait_done(lat, bok);
                qa = int'($signed(quotient));
                ra = int'($signed(remainder));
                n_chk++;
                if (lat != 8 || quotient !== 6'(qe) || remainder !== 6'(re)
                    || div_by_zero !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=8",
                             a, b, qa, ra, lat, $signed(6'(qe)), re);
                end
                n_chk++;
                if (6'(qa * b + ra) !== 6'(a) ||
                    (ra < 0 ? -ra : ra) >= (b < 0 ? -b : b)) begin
                    n_fail++;
                    $display("FAIL invariant %0d/%0d: got q=%0d r=%0d expected q*d+r==n, |r|<|d|",
                             a, b, qa, ra);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
